// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//   ID->EX pipeline register placed directly after the decode Control unit.
//   Captures the control bits, register-file read data, immediate, funct and
//   register addresses of one decoded instruction, resolves the destination
//   register from RegDst at capture time, and hands one beat per cycle to EX.
//
//   Elastic valid/ready on both sides. Storage is a main slot (M) that drives
//   the outputs and a skid slot (S) that absorbs the beat arriving in the same
//   cycle EX stalls, so ready_o never depends combinationally on ready_i.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                squash every held beat; the offered input is dropped
//   valid_i / ready_o      upstream handshake (decode side)
//   RegDst_i .. RDaddr_i   decoded instruction fields
//   valid_o / ready_i      downstream handshake (EX side)
//   ALUSrc_o .. WRaddr_o   fields of the beat held in M
//   RegWrite_o             M.RegWrite qualified by M.valid (0 on a bubble)
// -----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [5:0]        funct_i,
    input  logic [REG_AW-1:0] RSaddr_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic              RegWrite_o,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [5:0]        funct_o,
    output logic [REG_AW-1:0] RSaddr_o,
    output logic [REG_AW-1:0] RTaddr_o,
    output logic [REG_AW-1:0] WRaddr_o
);

    // One stored beat. RegDst is not kept: it is folded into wr_addr.
    typedef struct packed {
        logic              alu_src;
        logic [1:0]        alu_op;
        logic              reg_write;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [5:0]        funct;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] wr_addr;
    } beat_t;

    beat_t in_beat_s;
    beat_t m_r;
    beat_t s_r;
    logic  m_valid_r;
    logic  s_valid_r;
    logic  accept_s;
    logic  drain_s;

    // Upstream may push only while the skid slot is free and not in reset.
    assign ready_o  = ~s_valid_r & ~rst_i;
    assign accept_s = valid_i & ready_o & ~flush_i;
    assign drain_s  = m_valid_r & ready_i;

    // Pack the incoming fields and resolve the destination register.
    always_comb begin
        in_beat_s.alu_src   = ALUSrc_i;
        in_beat_s.alu_op    = ALUOp_i;
        in_beat_s.reg_write = RegWrite_i;
        in_beat_s.rs_data   = RSdata_i;
        in_beat_s.rt_data   = RTdata_i;
        in_beat_s.imm       = imm_i;
        in_beat_s.funct     = funct_i;
        in_beat_s.rs_addr   = RSaddr_i;
        in_beat_s.rt_addr   = RTaddr_i;
        in_beat_s.wr_addr   = RTaddr_i;
        if (RegDst_i) begin
            in_beat_s.wr_addr = RDaddr_i;
        end else begin
            in_beat_s.wr_addr = RTaddr_i;
        end
    end

    // Main/skid slot update: reset, then flush, then normal elastic flow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_r       <= '0;
            s_r       <= '0;
            m_valid_r <= 1'b0;
            s_valid_r <= 1'b0;
        end else if (flush_i) begin
            // Payload is left as-is; only the valid bits matter after a squash.
            m_valid_r <= 1'b0;
            s_valid_r <= 1'b0;
        end else if (!m_valid_r || drain_s) begin
            if (s_valid_r) begin
                // Skid beat is older than anything upstream; it goes first.
                m_r       <= s_r;
                m_valid_r <= 1'b1;
                s_valid_r <= 1'b0;
            end else if (accept_s) begin
                m_r       <= in_beat_s;
                m_valid_r <= 1'b1;
            end else begin
                m_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            // M is stalled: park the new beat, which also drops ready_o.
            s_r       <= in_beat_s;
            s_valid_r <= 1'b1;
        end else begin
            m_valid_r <= m_valid_r;
            s_valid_r <= s_valid_r;
        end
    end

    // Handshake and control outputs are forced to idle while reset is applied,
    // so they are clean even in the very first reset cycle.
    assign valid_o    = m_valid_r & ~rst_i;
    assign RegWrite_o = m_r.reg_write & m_valid_r & ~rst_i;
    assign ALUOp_o    = rst_i ? 2'b00 : m_r.alu_op;
    assign WRaddr_o   = rst_i ? {REG_AW{1'b0}} : m_r.wr_addr;

    assign ALUSrc_o   = m_r.alu_src;
    assign RSdata_o   = m_r.rs_data;
    assign RTdata_o   = m_r.rt_data;
    assign imm_o      = m_r.imm;
    assign funct_o    = m_r.funct;
    assign RSaddr_o   = m_r.rs_addr;
    assign RTaddr_o   = m_r.rt_addr;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe. The reference model treats the block as
// a FIFO of at most two beats: it accepts when fewer than two are held, the
// head is what EX sees, drains pop the head, reset and flush empty it.
module tb_id_ex_pipe;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, valid_i, ready_i;
    logic          RegDst_i, ALUSrc_i, RegWrite_i;
    logic [1:0]    ALUOp_i;
    logic [DW-1:0] RSdata_i, RTdata_i, imm_i;
    logic [5:0]    funct_i;
    logic [AW-1:0] RSaddr_i, RTaddr_i, RDaddr_i;
    logic          ready_o, valid_o, ALUSrc_o, RegWrite_o;
    logic [1:0]    ALUOp_o;
    logic [DW-1:0] RSdata_o, RTdata_o, imm_o;
    logic [5:0]    funct_o;
    logic [AW-1:0] RSaddr_o, RTaddr_o, WRaddr_o;

    typedef struct packed {
        logic          alusrc;
        logic [1:0]    aluop;
        logic          regwrite;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic [DW-1:0] imm;
        logic [5:0]    funct;
        logic [AW-1:0] rsa;
        logic [AW-1:0] rta;
        logic [AW-1:0] wra;
    } beat_t;

    beat_t q[$];
    beat_t out_beat;
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i),
        .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i), .RSdata_i(RSdata_i),
        .RTdata_i(RTdata_i), .imm_i(imm_i), .funct_i(funct_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .valid_o(valid_o), .ready_i(ready_i), .ALUSrc_o(ALUSrc_o),
        .ALUOp_o(ALUOp_o), .RegWrite_o(RegWrite_o), .RSdata_o(RSdata_o),
        .RTdata_o(RTdata_o), .imm_o(imm_o), .funct_o(funct_o),
        .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .WRaddr_o(WRaddr_o)
    );

    assign out_beat = {ALUSrc_o, ALUOp_o, RegWrite_o, RSdata_o, RTdata_o,
                       imm_o, funct_o, RSaddr_o, RTaddr_o, WRaddr_o};

    // Expected beat for the current inputs: destination chosen by RegDst.
    function automatic beat_t in_beat();
        beat_t b;
        b.alusrc = ALUSrc_i; b.aluop = ALUOp_i; b.regwrite = RegWrite_i;
        b.rs = RSdata_i; b.rt = RTdata_i; b.imm = imm_i; b.funct = funct_i;
        b.rsa = RSaddr_i; b.rta = RTaddr_i;
        b.wra = RegDst_i ? RDaddr_i : RTaddr_i;
        return b;
    endfunction

    function automatic bit exp_ready();
        return (q.size() < 2) && !rst_i;
    endfunction

    task automatic rand_payload();
        logic [31:0] r;
        r = $urandom();
        RegDst_i = r[0]; ALUSrc_i = r[1]; RegWrite_i = r[2]; ALUOp_i = r[4:3];
        funct_i = r[10:5]; RSaddr_i = r[15:11]; RTaddr_i = r[20:16];
        RDaddr_i = r[25:21];
        RSdata_i = $urandom(); RTdata_i = $urandom(); imm_i = $urandom();
    endtask

    // Advance one clock and update the FIFO model from pre-edge inputs.
    task automatic cycle();
        bit    acc, drn, clr;
        beat_t b;
        acc = valid_i && exp_ready() && !flush_i;
        drn = (q.size() > 0) && ready_i;
        clr = rst_i || flush_i;
        b   = in_beat();
        @(posedge clk);
        if (clr) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1; rand_payload();
        valid_i = 1'b1; RegWrite_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", valid_o); end
        cycle();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", valid_o); end
        checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", ready_o); end
        checks++; if (ALUOp_o !== 2'b00 || WRaddr_o !== 5'd0) begin errors++; $display("FAIL reset_fields: got aluop=%b wr=%0d want 00/0", ALUOp_o, WRaddr_o); end
        cycle();
        rst_i = 1'b0; valid_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_regdst();
        ready_i = 1'b1; rand_payload();
        valid_i = 1'b1; RegDst_i = 1'b1; ALUOp_i = 2'b11; RegWrite_i = 1'b1;
        ALUSrc_i = 1'b0; RDaddr_i = 5'd8; RTaddr_i = 5'd9;
        cycle();
        rand_payload();
        RegDst_i = 1'b0; ALUOp_i = 2'b10; ALUSrc_i = 1'b1; RegWrite_i = 1'b1; RTaddr_i = 5'd9;
        checks++; if (valid_o !== 1'b1 || WRaddr_o !== 5'd8 || ALUOp_o !== 2'b11) begin errors++; $display("FAIL rtype_out: got v=%b wr=%0d op=%b want 1/8/11", valid_o, WRaddr_o, ALUOp_o); end
        checks++; if (out_beat !== q[0]) begin errors++; $display("FAIL rtype_beat: got %h want %h", out_beat, q[0]); end
        cycle();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || WRaddr_o !== 5'd9 || ALUOp_o !== 2'b10 || ALUSrc_o !== 1'b1) begin errors++; $display("FAIL ori_out: got v=%b wr=%0d op=%b src=%b want 1/9/10/1", valid_o, WRaddr_o, ALUOp_o, ALUSrc_o); end
        cycle();
        checks++; if (valid_o !== 1'b0 || RegWrite_o !== 1'b0) begin errors++; $display("FAIL regdst_idle: got v=%b rw=%b want 0/0", valid_o, RegWrite_o); end
    endtask

    task automatic test_back_to_back();
        beat_t exp[3];
        beat_t got[3];
        int n = 0, first = -1, last = -1;
        bit acc_c;
        ready_i = 1'b0; valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_payload();
            exp[k] = in_beat();
            if (k < 2) cycle();
        end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", ready_o); end
        cycle();
        checks++; if (out_beat !== exp[0] || valid_o !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %h want %h", out_beat, exp[0]); end
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (valid_o && ready_i) begin
                if (n < 3) got[n] = out_beat;
                n++;
                if (first < 0) first = i;
                last = i;
            end
            acc_c = valid_i && exp_ready();
            cycle();
            if (acc_c) valid_i = 1'b0;
            #1;
        end
        checks++; if (n !== 3 || last - first !== 2) begin errors++; $display("FAIL b2b_count: got n=%0d span=%0d want 3/2", n, last - first); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL b2b_order%0d: got %h want %h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        rand_payload(); cycle();
        rand_payload(); cycle();
        flush_i = 1'b1; rand_payload(); RegWrite_i = 1'b1;
        cycle();
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || RegWrite_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL flush_state: got v=%b rw=%b rdy=%b want 0/0/1", valid_o, RegWrite_o, ready_o); end
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_d%0d: got %b want 0", i, valid_o); end
        end
    endtask

    task automatic test_stream();
        beat_t prev;
        ready_i = 1'b0; valid_i = 1'b1; rand_payload();
        cycle();
        ready_i = 1'b1;
        prev = out_beat;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            #1;
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, ready_o); end
            cycle();
            checks++; if (valid_o !== 1'b1 || out_beat !== q[0]) begin errors++; $display("FAIL stream_beat%0d: got v=%b %h want %h", i, valid_o, out_beat, q[0]); end
            checks++; if (out_beat === prev) begin errors++; $display("FAIL stream_distinct%0d: got %h repeated", i, out_beat); end
            prev = out_beat;
        end
        valid_i = 1'b0;
        cycle(); cycle();
    endtask

    task automatic test_reset_full();
        beat_t e;
        ready_i = 1'b0; valid_i = 1'b1;
        rand_payload(); cycle();
        rand_payload(); cycle();
        rst_i = 1'b1; cycle();
        rst_i = 1'b0; valid_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rstfull_state: got v=%b rdy=%b want 0/1", valid_o, ready_o); end
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstfull_empty%0d: got %b want 0", i, valid_o); end
        end
        valid_i = 1'b1; rand_payload(); e = in_beat();
        cycle();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || out_beat !== e) begin errors++; $display("FAIL rstfull_new: got v=%b %h want 1 %h", valid_o, out_beat, e); end
        cycle();
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            rand_payload();
            valid_i = r[0] | r[1];
            ready_i = r[2] | r[3];
            flush_i = (r[7:4] == 4'd0);
            rst_i   = (r[13:8] == 6'd0);
            #1;
            checks++; if (ready_o !== exp_ready()) begin errors++; $display("FAIL rand_ready%0d: got %b want %b", i, ready_o, exp_ready()); end
            cycle();
            rst_i = 1'b0; flush_i = 1'b0;
            #1;
            checks++; if (valid_o !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid%0d: got %b want %b", i, valid_o, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (out_beat !== q[0]) begin errors++; $display("FAIL rand_beat%0d: got %h want %h", i, out_beat, q[0]); end
            end else begin
                checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL rand_bubble_rw%0d: got %b want 0", i, RegWrite_o); end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        rand_payload();
        test_reset();
        test_regdst();
        test_back_to_back();
        test_flush();
        test_stream();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
